multi_core_dispatcher: RTL and testbench
========================================

Name: multi_core_dispatcher

Overview:
- Parametrised successor to the single-core pipeline top: fans one bot job stream out to NUM_CORES computeModule instances and merges their results into one collector write stream.
- Sits between the input permutation handler and the collection module.
- Adds over the single-core design: an input job FIFO, round-robin dispatch to idle cores, per-core result holding, round-robin result merge, and sticky error flags.

Parameters:
NUM_CORES, 4, number of compute cores served (1..16)
EXTRA_DATA_WIDTH, 16, side data carried with each job (address + sub-address)
FIFO_DEPTH, 32, job FIFO entries, power of two
ALMOST_FULL_MARGIN, 4, almostFull asserted when occupancy >= FIFO_DEPTH-ALMOST_FULL_MARGIN

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
jobValid  in  1  push job this cycle
jobBot  in  128  bot graph
jobExtra  in  EXTRA_DATA_WIDTH  side data
fifoFullness  out  $clog2(FIFO_DEPTH)+1  registered occupancy
almostFull  out  1  registered; producer must stop pushing
coreRequest  in  NUM_CORES  one-cycle pulse: core i can take a job
coreBotValid  out  NUM_CORES  one-hot, job handed to core i
coreBot  out  128  shared job bus
coreExtra  out  EXTRA_DATA_WIDTH  shared side-data bus
coreDone  in  NUM_CORES  core i result valid (one-cycle pulse)
coreCount  in  6*NUM_CORES  core i count at [6i+:6]
coreExtraOut  in  EXTRA_DATA_WIDTH*NUM_CORES  core i side data
resultValid  out  1  merged write strobe to the collector
resultCount  out  6  merged count
resultExtra  out  EXTRA_DATA_WIDTH  merged side data
errFifoOverflow  out  1  sticky
errResultOverrun  out  1  sticky

Behaviour:
- Reset: all outputs 0, FIFO empty, pending bits 0, round-robin pointers 0, holding registers empty, sticky errors cleared. Reset mid-operation discards all in-flight jobs and results; cores are reset by the same rst.
- FIFO push: on jobValid when occupancy < FIFO_DEPTH. Push while full is dropped and sets errFifoOverflow, even if a pop occurs in the same cycle. Pointers wrap modulo FIFO_DEPTH.
- fifoFullness/almostFull: registered, lag true occupancy by one cycle.
- Pending: coreRequest[i] sets pending[i]; pending[i] is cleared when core i is served. A request arriving while pending[i] is already set is idempotent.
- Dispatch: each cycle, if FIFO is non-empty and any pending bit is set, pick the lowest-index pending core at or after dispatchPtr (wrapping) and pop one entry.
  - Next cycle: coreBotValid is one-hot for that core, with coreBot/coreExtra holding the popped data; otherwise coreBotValid = 0 and the buses hold their last value.
  - dispatchPtr advances to winner+1 mod NUM_CORES.
  - At most one dispatch per cycle.
  - Latency: push at t into an empty FIFO with a core pending gives coreBotValid at t+2.
- Result holding: coreDone[i] loads holding register i (count, extra).
  - If holding i is occupied and not drained that cycle, the new result is dropped and errResultOverrun is set.
  - If holding i is drained in the same cycle, the new result is accepted.
- Merge: each cycle, round-robin (mergePtr) select one occupied holding register and present it as resultValid/resultCount/resultExtra on the next cycle. No backpressure on the result side.
  - Latency: coreDone at t with no contention gives resultValid at t+2.
  - N simultaneous dones emerge on N consecutive cycles.
- Job ordering across cores is not preserved. Ordering per core is preserved.

Optional Feature:
- Macro: DISPATCHER_STATS_EN.
- When defined: adds outputs statJobsIn[31:0], statJobsDispatched[31:0] and statResultsOut[31:0]. Each is a saturating counter, reset to 0, incremented on accepted push, coreBotValid and resultValid respectively.
- When undefined: these ports and counters do not exist; everything else is identical.

Decomposition:
- Shared package/header: job width 128, count width 6, a round-robin next-index function, and the $clog2-derived pointer widths.
- Natural sub-module: rr_arbiter (NUM_CORES request vector + pointer → one-hot grant, next pointer). Instantiated twice, once for dispatch and once for merge.
- The FIFO is an in-block memory with registered output.

Test Plan:
- Basic path, NUM_CORES=4: coreRequest=4'b0001 at t=0; push one job (extra=16'h0005) at t=1 → coreBotValid=4'b0001 with extra 16'h0005 at t=3. Core pulses done with count 6'd17 at t=10 → resultValid, count 17, extra 16'h0005 at t=12.
- Round-robin dispatch: all four cores pending, push 8 jobs back-to-back → coreBotValid grants 0,1,2,3 on consecutive cycles, then no further grants until cores re-request. FIFO holds 4 entries.
- Simultaneous results: coreDone=4'b1111 in one cycle with counts 1,2,3,4 → resultValid on 4 consecutive cycles carrying counts 1,2,3,4 in mergePtr order; no errors.
- Overflow: FIFO_DEPTH=32, no core requests, push 33 jobs → fifoFullness=32, almostFull high from occupancy 28, errFifoOverflow=1, and 32 jobs are later dispatched.
- Result overrun: hold merge busy with cores 0-3 done, then core 3 done again before its register drains → errResultOverrun=1 and only the first core-3 result is emitted.
- Reset mid-operation: assert rst with 5 jobs queued and 2 results held → all outputs 0 immediately (asynchronous); after release, no stale results or grants appear.

Source files
------------

// File: rtl/multi_core_dispatcher_pkg.sv
// Shared widths and helpers for the multi-core dispatcher: job/count widths,
// pointer-width derivation and the round-robin successor index.
package multi_core_dispatcher_pkg;

    localparam int JOB_W = 128;
    localparam int CNT_W = 6;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/multi_core_dispatcher_rr_arbiter.sv
// Round-robin arbiter: grants the lowest-index requester at or after ptr_i
// (wrapping) and reports the index just past the winner as the next pointer.
module multi_core_dispatcher_rr_arbiter
    import multi_core_dispatcher_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o,
    output logic [PW-1:0] next_ptr_o
);

    logic [PW-1:0] cand_s;

    // Scan from the pointer upwards, first requester wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = PW'((int'(ptr_i) + k >= N) ? int'(ptr_i) + k - N : int'(ptr_i) + k);
            if (!valid_o && req_i[cand_s]) begin
                valid_o         = 1'b1;
                grant_o[cand_s] = 1'b1;
                idx_o           = cand_s;
            end else begin
                valid_o = valid_o;
            end
        end
        next_ptr_o = valid_o ? PW'(rr_next(int'(idx_o), N)) : ptr_i;
    end

endmodule

// File: rtl/multi_core_dispatcher.sv
// Fans one job stream out to NUM_CORES compute cores and merges their results.
// Optional saturating statistics counters are enabled by DISPATCHER_STATS_EN.
module multi_core_dispatcher
    import multi_core_dispatcher_pkg::*;
#(
    parameter int NUM_CORES          = 4,
    parameter int EXTRA_DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH         = 32,
    parameter int ALMOST_FULL_MARGIN = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 jobValid_i,
    input  logic [JOB_W-1:0]                     jobBot_i,
    input  logic [EXTRA_DATA_WIDTH-1:0]          jobExtra_i,
    output logic [$clog2(FIFO_DEPTH):0]          fifoFullness_o,
    output logic                                 almostFull_o,
    input  logic [NUM_CORES-1:0]                 coreRequest_i,
    output logic [NUM_CORES-1:0]                 coreBotValid_o,
    output logic [JOB_W-1:0]                     coreBot_o,
    output logic [EXTRA_DATA_WIDTH-1:0]          coreExtra_o,
    input  logic [NUM_CORES-1:0]                 coreDone_i,
    input  logic [CNT_W*NUM_CORES-1:0]           coreCount_i,
    input  logic [EXTRA_DATA_WIDTH*NUM_CORES-1:0] coreExtraOut_i,
    output logic                                 resultValid_o,
    output logic [CNT_W-1:0]                     resultCount_o,
    output logic [EXTRA_DATA_WIDTH-1:0]          resultExtra_o,
    output logic                                 errFifoOverflow_o,
    output logic                                 errResultOverrun_o
`ifdef DISPATCHER_STATS_EN
    ,
    output logic [31:0]                          statJobsIn_o,
    output logic [31:0]                          statJobsDispatched_o,
    output logic [31:0]                          statResultsOut_o
`endif
);

    localparam int PW = ptr_w(NUM_CORES);
    localparam int AW = ptr_w(FIFO_DEPTH);
    localparam int FW = AW + 1;
    localparam int EW = EXTRA_DATA_WIDTH;

    logic [JOB_W+EW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [FW-1:0]        count_q, count_d;
    logic [NUM_CORES-1:0] pending_q;
    logic [PW-1:0]        disp_ptr_q, merge_ptr_q;
    logic [NUM_CORES-1:0] hold_valid_q;
    logic [CNT_W-1:0]     hold_cnt_q   [NUM_CORES];
    logic [EW-1:0]        hold_extra_q [NUM_CORES];

    logic [FW-1:0]        fullness_q;
    logic                 almost_q, err_ovf_q, err_ovr_q, res_valid_q;
    logic [NUM_CORES-1:0] bot_valid_q;
    logic [JOB_W-1:0]     bot_q;
    logic [EW-1:0]        bot_extra_q, res_extra_q;
    logic [CNT_W-1:0]     res_cnt_q;

    logic                 push_s, pop_s, overflow_s, overrun_s;
    logic [NUM_CORES-1:0] disp_req_s, disp_gnt_s, merge_gnt_s, accept_s;
    logic [PW-1:0]        disp_idx_s, disp_next_s, merge_idx_s, merge_next_s;
    logic                 merge_any_s;

    multi_core_dispatcher_rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_disp_arb (
        .req_i(disp_req_s), .ptr_i(disp_ptr_q), .grant_o(disp_gnt_s),
        .idx_o(disp_idx_s), .valid_o(pop_s), .next_ptr_o(disp_next_s)
    );

    multi_core_dispatcher_rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_merge_arb (
        .req_i(hold_valid_q), .ptr_i(merge_ptr_q), .grant_o(merge_gnt_s),
        .idx_o(merge_idx_s), .valid_o(merge_any_s), .next_ptr_o(merge_next_s)
    );

    // Push acceptance is judged on current occupancy, so a same-cycle pop never rescues a full push
    always_comb begin
        push_s     = jobValid_i && (count_q < FW'(FIFO_DEPTH));
        overflow_s = jobValid_i && !push_s;
        disp_req_s = (count_q != '0) ? pending_q : '0;
        accept_s   = coreDone_i & (~hold_valid_q | merge_gnt_s);
        overrun_s  = |(coreDone_i & hold_valid_q & ~merge_gnt_s);
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + FW'(1);
            2'b01:   count_d = count_q - FW'(1);
            default: count_d = count_q;
        endcase
    end

    // Job storage; contents are don't-care until written so no reset is needed
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {jobBot_i, jobExtra_i};
        end
    end

    // Control state, holding registers and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pending_q    <= '0;
            disp_ptr_q   <= '0;
            merge_ptr_q  <= '0;
            hold_valid_q <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                hold_cnt_q[i]   <= '0;
                hold_extra_q[i] <= '0;
            end
            fullness_q   <= '0;
            almost_q     <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_ovr_q    <= 1'b0;
            bot_valid_q  <= '0;
            bot_q        <= '0;
            bot_extra_q  <= '0;
            res_valid_q  <= 1'b0;
            res_cnt_q    <= '0;
            res_extra_q  <= '0;
        end else begin
            wr_ptr_q     <= push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q     <= pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_q      <= count_d;
            pending_q    <= (pending_q & ~disp_gnt_s) | coreRequest_i;
            disp_ptr_q   <= disp_next_s;
            merge_ptr_q  <= merge_next_s;
            hold_valid_q <= (hold_valid_q & ~merge_gnt_s) | accept_s;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (accept_s[i]) begin
                    hold_cnt_q[i]   <= coreCount_i[CNT_W*i +: CNT_W];
                    hold_extra_q[i] <= coreExtraOut_i[EW*i +: EW];
                end
            end
            fullness_q   <= count_q;
            almost_q     <= count_q >= FW'(FIFO_DEPTH - ALMOST_FULL_MARGIN);
            err_ovf_q    <= err_ovf_q | overflow_s;
            err_ovr_q    <= err_ovr_q | overrun_s;
            bot_valid_q  <= pop_s ? disp_gnt_s : '0;
            if (pop_s) begin
                {bot_q, bot_extra_q} <= mem_q[rd_ptr_q];
            end
            res_valid_q  <= merge_any_s;
            if (merge_any_s) begin
                res_cnt_q   <= hold_cnt_q[merge_idx_s];
                res_extra_q <= hold_extra_q[merge_idx_s];
            end
        end
    end

    assign fifoFullness_o     = fullness_q;
    assign almostFull_o       = almost_q;
    assign coreBotValid_o     = bot_valid_q;
    assign coreBot_o          = bot_q;
    assign coreExtra_o        = bot_extra_q;
    assign resultValid_o      = res_valid_q;
    assign resultCount_o      = res_cnt_q;
    assign resultExtra_o      = res_extra_q;
    assign errFifoOverflow_o  = err_ovf_q;
    assign errResultOverrun_o = err_ovr_q;

`ifdef DISPATCHER_STATS_EN
    logic [31:0] st_in_q, st_disp_q, st_out_q;

    // Saturating event counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_in_q   <= '0;
            st_disp_q <= '0;
            st_out_q  <= '0;
        end else begin
            if (push_s && !(&st_in_q)) st_in_q <= st_in_q + 32'd1;
            if ((|bot_valid_q) && !(&st_disp_q)) st_disp_q <= st_disp_q + 32'd1;
            if (res_valid_q && !(&st_out_q)) st_out_q <= st_out_q + 32'd1;
        end
    end

    assign statJobsIn_o         = st_in_q;
    assign statJobsDispatched_o = st_disp_q;
    assign statResultsOut_o     = st_out_q;
`endif

endmodule

// File: tb/tb_multi_core_dispatcher.sv
// Self-checking bench for multi_core_dispatcher: per-cycle vector table plus
// directed sequences for arbitration, overflow, overrun and mid-run reset.
module tb_multi_core_dispatcher;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         jobValid = 1'b0;
    logic [127:0] jobBot;
    logic [15:0]  jobExtra = 16'h0;
    logic [5:0]   fifoFullness;
    logic         almostFull;
    logic [3:0]   coreRequest = 4'h0;
    logic [3:0]   coreBotValid;
    logic [127:0] coreBot;
    logic [15:0]  coreExtra;
    logic [3:0]   coreDone = 4'h0;
    logic [23:0]  coreCount = 24'h0;
    logic [63:0]  coreExtraOut = 64'h0;
    logic         resultValid;
    logic [5:0]   resultCount;
    logic [15:0]  resultExtra;
    logic         errFifoOverflow, errResultOverrun;
`ifdef DISPATCHER_STATS_EN
    logic [31:0]  statJobsIn, statJobsDispatched, statResultsOut;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign jobBot = {8{jobExtra}};

    multi_core_dispatcher #(
        .NUM_CORES(4), .EXTRA_DATA_WIDTH(16), .FIFO_DEPTH(32), .ALMOST_FULL_MARGIN(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .jobValid_i(jobValid), .jobBot_i(jobBot),
        .jobExtra_i(jobExtra), .fifoFullness_o(fifoFullness), .almostFull_o(almostFull),
        .coreRequest_i(coreRequest), .coreBotValid_o(coreBotValid), .coreBot_o(coreBot),
        .coreExtra_o(coreExtra), .coreDone_i(coreDone), .coreCount_i(coreCount),
        .coreExtraOut_i(coreExtraOut), .resultValid_o(resultValid),
        .resultCount_o(resultCount), .resultExtra_o(resultExtra),
        .errFifoOverflow_o(errFifoOverflow), .errResultOverrun_o(errResultOverrun)
`ifdef DISPATCHER_STATS_EN
        , .statJobsIn_o(statJobsIn), .statJobsDispatched_o(statJobsDispatched),
        .statResultsOut_o(statResultsOut)
`endif
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        push;
        logic [15:0] ext;
        logic [3:0]  done;
        logic [23:0] cnts;
        logic [63:0] xo;
        logic [3:0]  bv;
        logic [15:0] cx;
        logic [5:0]  ff;
        logic        rv;
        logic [5:0]  rc;
        logic [15:0] rx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic [3:0] rq, input logic p,
                               input logic [15:0] e, input logic [3:0] d, input logic [23:0] c,
                               input logic [63:0] x, input logic [3:0] bv, input logic [15:0] cx,
                               input logic [5:0] ff, input logic rv, input logic [5:0] rc,
                               input logic [15:0] rx);
        vec_t t;
        t.rst = r; t.req = rq; t.push = p; t.ext = e; t.done = d; t.cnts = c; t.xo = x;
        t.bv = bv; t.cx = cx; t.ff = ff; t.rv = rv; t.rc = rc; t.rx = rx;
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        jobValid = 1'b0; jobExtra = 16'h0; coreRequest = 4'h0;
        coreDone = 4'h0; coreCount = 24'h0; coreExtraOut = 64'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0]  bv_e;
    logic [15:0] cx_e;
    logic [5:0]  exp_res[$];
    int          n, stale, kk;

    initial begin
        // Basic path: request t=0, push t=1, grant t=3; done t=10, result t=12
        vecs.push_back(v(1, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h0, 6'd0, 0, 6'd0, 16'h0));
        vecs.push_back(v(0, 4'h1, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h0, 6'd0, 0, 6'd0, 16'h0));
        vecs.push_back(v(0, 4'h0, 1, 16'h5, 4'h0, 24'h0, 64'h0, 4'h0, 16'h0, 6'd0, 0, 6'd0, 16'h0));
        vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h0, 6'd0, 0, 6'd0, 16'h0));
        vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h1, 16'h5, 6'd1, 0, 6'd0, 16'h0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h5, 6'd0, 0, 6'd0, 16'h0));
        vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'h1, 24'd17, 64'h5, 4'h0, 16'h5, 6'd0, 0, 6'd0, 16'h0));
        vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h5, 6'd0, 0, 6'd0, 16'h0));
        vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h5, 6'd0, 1, 6'd17, 16'h5));
        vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h5, 6'd0, 0, 6'd17, 16'h5));
        // Simultaneous results from reset: counts 1..4 emerge in core order
        vecs.push_back(v(1, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h0, 6'd0, 0, 6'd0, 16'h0));
        vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'hF, {6'd4, 6'd3, 6'd2, 6'd1},
                         64'h000D_000C_000B_000A, 4'h0, 16'h0, 6'd0, 0, 6'd0, 16'h0));
        vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h0, 6'd0, 0, 6'd0, 16'h0));
        vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h0, 6'd0, 1, 6'd1, 16'hA));
        vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h0, 6'd0, 1, 6'd2, 16'hB));
        vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h0, 6'd0, 1, 6'd3, 16'hC));
        vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h0, 6'd0, 1, 6'd4, 16'hD));
        vecs.push_back(v(0, 4'h0, 0, 16'h0, 4'h0, 24'h0, 64'h0, 4'h0, 16'h0, 6'd0, 0, 6'd4, 16'hD));

        tick();
        tick();
        foreach (vecs[i]) begin
            rst = vecs[i].rst; coreRequest = vecs[i].req; jobValid = vecs[i].push;
            jobExtra = vecs[i].ext; coreDone = vecs[i].done; coreCount = vecs[i].cnts;
            coreExtraOut = vecs[i].xo;
            #1;
            chk($sformatf("vec%0d coreBotValid", i), 128'(coreBotValid), 128'(vecs[i].bv));
            chk($sformatf("vec%0d coreExtra", i), 128'(coreExtra), 128'(vecs[i].cx));
            chk($sformatf("vec%0d coreBot", i), coreBot, {8{vecs[i].cx}});
            chk($sformatf("vec%0d fifoFullness", i), 128'(fifoFullness), 128'(vecs[i].ff));
            chk($sformatf("vec%0d resultValid", i), 128'(resultValid), 128'(vecs[i].rv));
            chk($sformatf("vec%0d resultCount", i), 128'(resultCount), 128'(vecs[i].rc));
            chk($sformatf("vec%0d resultExtra", i), 128'(resultExtra), 128'(vecs[i].rx));
            chk($sformatf("vec%0d errors", i), 128'({errFifoOverflow, errResultOverrun}), 128'(0));
            @(posedge clk);
            #1;
        end

        // Round-robin dispatch: all four pending, eight pushes
        do_reset();
        coreRequest = 4'hF;
        tick();
        coreRequest = 4'h0;
        cx_e = 16'h0;
        for (int k = 0; k < 16; k++) begin
            jobValid = (k < 8);
            jobExtra = 16'h100 + 16'(k);
            bv_e = 4'h0;
            if (k >= 2 && k <= 5) begin
                bv_e = 4'b0001 << (k - 2);
                cx_e = 16'h100 + 16'(k - 2);
            end
            chk($sformatf("rr grant k%0d", k), 128'(coreBotValid), 128'(bv_e));
            chk($sformatf("rr extra k%0d", k), 128'(coreExtra), 128'(cx_e));
            tick();
        end
        jobValid = 1'b0;
        chk("rr fifoFullness", 128'(fifoFullness), 128'(4));
        chk("rr almostFull", 128'(almostFull), 128'(0));

        // Overflow: 33 pushes with no requests, then drain
        do_reset();
        for (int k = 0; k < 33; k++) begin
            jobValid = 1'b1;
            jobExtra = 16'(k);
            tick();
            kk = (k < 32) ? k : 32;
            chk($sformatf("ovf fullness k%0d", k), 128'(fifoFullness), 128'(kk));
            chk($sformatf("ovf almostFull k%0d", k), 128'(almostFull), 128'(kk >= 28));
            chk($sformatf("ovf err k%0d", k), 128'(errFifoOverflow), 128'(k == 32));
        end
        jobValid = 1'b0;
        tick();
        chk("ovf full", 128'(fifoFullness), 128'(32));
        chk("ovf almostFull", 128'(almostFull), 128'(1));
        chk("ovf err sticky", 128'(errFifoOverflow), 128'(1));
        n = 0;
        for (int c = 0; c < 80; c++) begin
            coreRequest = 4'hF;
            tick();
            if (coreBotValid != 4'h0) begin
                chk("ovf onehot", 128'($onehot(coreBotValid)), 128'(1));
                chk($sformatf("ovf order %0d", n), 128'(coreExtra), 128'(n));
                n++;
            end
        end
        coreRequest = 4'h0;
        chk("ovf dispatched", 128'(n), 128'(32));
        tick();
        tick();
        chk("ovf drained", 128'(fifoFullness), 128'(0));
        chk("ovf err after drain", 128'(errFifoOverflow), 128'(1));

        // Result overrun: core 3 finishes again before its holding register drains
        do_reset();
        coreDone = 4'hF; coreCount = {6'd4, 6'd3, 6'd2, 6'd1};
        coreExtraOut = 64'h000D_000C_000B_000A;
        tick();
        coreDone = 4'h8; coreCount = {6'd9, 18'h0}; coreExtraOut = {16'hE, 48'h0};
        tick();
        clear_inputs();
        exp_res = '{6'd1, 6'd2, 6'd3, 6'd4};
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (resultValid) begin
                if (n < 4) chk($sformatf("ovr result %0d", n), 128'(resultCount), 128'(exp_res[n]));
                n++;
            end
            tick();
        end
        chk("ovr result total", 128'(n), 128'(4));
        chk("ovr err", 128'(errResultOverrun), 128'(1));

        // Same-cycle drain and refill is accepted without error
        do_reset();
        coreDone = 4'h1; coreCount = 24'd5; coreExtraOut = 64'h5;
        tick();
        coreCount = 24'd6; coreExtraOut = 64'h6;
        tick();
        clear_inputs();
        exp_res = '{6'd5, 6'd6};
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (resultValid) begin
                if (n < 2) chk($sformatf("refill result %0d", n), 128'(resultCount), 128'(exp_res[n]));
                n++;
            end
            tick();
        end
        chk("refill total", 128'(n), 128'(2));
        chk("refill no err", 128'(errResultOverrun), 128'(0));

        // Reset mid-operation with jobs queued and results held
        do_reset();
        for (int k = 0; k < 5; k++) begin
            jobValid = 1'b1;
            jobExtra = 16'h200 + 16'(k);
            tick();
        end
        jobValid = 1'b0;
        coreDone = 4'h3; coreCount = {12'h0, 6'd8, 6'd7}; coreExtraOut = 64'h0000_0000_0021_0020;
        tick();
        clear_inputs();
        chk("mid pre fullness", 128'(fifoFullness), 128'(5));
        rst = 1'b1;
        #1;
        chk("mid fullness", 128'(fifoFullness), 128'(0));
        chk("mid resultValid", 128'(resultValid), 128'(0));
        chk("mid resultCount", 128'(resultCount), 128'(0));
        chk("mid coreBotValid", 128'(coreBotValid), 128'(0));
        chk("mid coreExtra", 128'(coreExtra), 128'(0));
        tick();
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            coreRequest = 4'hF;
            tick();
            if (coreBotValid != 4'h0 || resultValid) stale++;
        end
        coreRequest = 4'h0;
        chk("mid no stale", 128'(stale), 128'(0));
        chk("mid errors", 128'({errFifoOverflow, errResultOverrun}), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
